router_out_tx: RTL

Serial output-port transmitter for the router fabric: accepts whole packets as a byte stream and drives one router output lane with the `dout` / `valido_n` / `frameo_n` serial protocol. It is used to build the DUT-side output stage and the bench reference model. A receive monitor sampling `dout`, `valido_n` and `frameo_n` on the rising edge sees legal frames. Bytes are buffered in an internal FIFO and serialized LSB first, one bit per clock.

---
 rtl/router_out_tx_if.sv | 22 ++
 rtl/router_out_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_tx_if.sv
// Byte-stream input port of the router output transmitter: packet bytes with
// an end-of-packet flag and a ready/valid handshake.
interface router_out_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/router_out_tx.sv
// Router output-lane transmitter: buffers packet bytes and serializes them LSB
// first on dout/valido_n/frameo_n. ROUTER_TX_CUT_THROUGH_EN selects cut-through.
module router_out_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int IDLE_GAP   = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  router_out_tx_if.slave  in_if,
  output logic            dout,
  output logic            valido_n,
  output logic            frameo_n,
  output logic            busy,
  output logic            err_trunc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_STALL} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      bit_reg, bit_next;
  logic [GW-1:0]   gap_reg, gap_next;
  logic [7:0]      sr_reg;
  logic            byte_last_reg;
  logic            dout_reg, dout_next;
  logic            valido_n_reg, valido_n_next;
  logic            frameo_n_reg, frameo_n_next;
  logic            busy_reg;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            fifo_full;
  logic            in_fire;
  logic            push_en;
  logic            push_last;
  logic            pop;
  logic            shift;
  logic            start;

  assign in_fire   = in_if.in_valid & in_if.in_ready;
  assign fifo_full = (count_reg == FULL_CNT);

`ifdef ROUTER_TX_CUT_THROUGH_EN
  logic fifo_empty;

  assign fifo_empty     = (count_reg == '0);
  assign in_if.in_ready = ~fifo_full;
  assign push_en        = in_fire;
  assign push_last      = in_if.in_last;
  assign start          = ~fifo_empty;
  assign err_trunc      = 1'b0;
`else
  logic [CW-1:0] pkt_cnt_reg, pkt_cnt_next;
  logic          discard_reg, discard_next;
  logic          err_trunc_reg;
  logic          trunc;
  logic          pop_last;
  logic          last_flag_reg [FIFO_DEPTH];

  assign in_if.in_ready = ~fifo_full | discard_reg;
  assign push_en        = in_fire & ~discard_reg;
  // With no complete packet buffered nothing can pop, so this push fills the FIFO.
  assign trunc          = push_en & ~in_if.in_last & (count_reg == FULL_CNT - 1'b1)
                          & (pkt_cnt_reg == '0);
  assign push_last      = in_if.in_last | trunc;
  assign start          = (pkt_cnt_reg != '0);
  assign err_trunc      = err_trunc_reg;

  // End-of-packet flags mirrored in flops so pkt_cnt can track the pop edge.
  genvar gi;
  for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_last_flag
    always_ff @(posedge clock) begin
      if (!reset_n)
        last_flag_reg[gi] <= 1'b0;
      else if (push_en && (wr_ptr_reg == AW'(gi)))
        last_flag_reg[gi] <= push_last;
    end
  end

  assign pop_last = last_flag_reg[rd_ptr_reg];

  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    discard_next = discard_reg;
    if ((push_en & push_last) && !(pop & pop_last))
      pkt_cnt_next = pkt_cnt_reg + 1'b1;
    else if (!(push_en & push_last) && (pop & pop_last))
      pkt_cnt_next = pkt_cnt_reg - 1'b1;
    if (trunc)
      discard_next = 1'b1;
    else if (in_fire && discard_reg && in_if.in_last)
      discard_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pkt_cnt_reg   <= '0;
      discard_reg   <= 1'b0;
      err_trunc_reg <= 1'b0;
    end else begin
      pkt_cnt_reg   <= pkt_cnt_next;
      discard_reg   <= discard_next;
      err_trunc_reg <= trunc;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage plus registered read straight into the shift register.
  always_ff @(posedge clock) begin
    if (push_en)
      mem[wr_ptr_reg] <= {push_last, in_if.in_data};
    if (pop) begin
      sr_reg        <= mem[rd_ptr_reg][7:0];
      byte_last_reg <= mem[rd_ptr_reg][8];
    end else if (shift) begin
      sr_reg <= {1'b0, sr_reg[7:1]};
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_next      = bit_reg;
    gap_next      = gap_reg;
    pop           = 1'b0;
    shift         = 1'b0;
    dout_next     = 1'b0;
    valido_n_next = 1'b1;
    frameo_n_next = 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          pop        = 1'b1;
          bit_next   = 3'd0;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        dout_next     = sr_reg[0];
        valido_n_next = 1'b0;
        frameo_n_next = 1'b0;
        if (bit_reg == 3'd7) begin
          bit_next = 3'd0;
          if (byte_last_reg) begin
            frameo_n_next = 1'b1;
            gap_next      = '0;
            state_next    = S_GAP;
          end
`ifdef ROUTER_TX_CUT_THROUGH_EN
          else if (fifo_empty) begin
            state_next = S_STALL;
          end
`endif
          else begin
            pop = 1'b1;
          end
        end else begin
          shift    = 1'b1;
          bit_next = bit_reg + 3'd1;
        end
      end
      S_GAP: begin
        if (gap_reg == GAP_LAST)
          state_next = S_IDLE;
        else
          gap_next = gap_reg + 1'b1;
      end
`ifdef ROUTER_TX_CUT_THROUGH_EN
      S_STALL: begin
        frameo_n_next = 1'b0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_SEND;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      bit_reg      <= 3'd0;
      gap_reg      <= '0;
      dout_reg     <= 1'b0;
      valido_n_reg <= 1'b1;
      frameo_n_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_reg      <= bit_next;
      gap_reg      <= gap_next;
      dout_reg     <= dout_next;
      valido_n_reg <= valido_n_next;
      frameo_n_reg <= frameo_n_next;
      busy_reg     <= (state_next != S_IDLE);
    end
  end

  assign dout     = dout_reg;
  assign valido_n = valido_n_reg;
  assign frameo_n = frameo_n_reg;
  assign busy     = busy_reg;

endmodule
